// File: rtl/operator_frame_tx.sv
// operator_frame_tx: captures one TKEO/ED/ASO/ADO sample per strobe and streams it as a byte frame.
// Define OPFRAME_CHECKSUM_EN to append an XOR checksum byte (15-byte frame instead of 14).
module operator_frame_tx #(
    parameter int         OUT_BITS  = 29,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [OUT_BITS-1:0] tkeo_in,
    input  logic [OUT_BITS-1:0] ed_in,
    input  logic [15:0]         aso_in,
    input  logic [15:0]         ado_in,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

`ifdef OPFRAME_CHECKSUM_EN
    localparam int N = 15;
`else
    localparam int N = 14;
`endif
    localparam int         FW       = 8 * N;
    localparam int         PW       = 8 * 14;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [7:0]    seq;
    logic [PW-1:0] payload;
    logic [FW-1:0] frame_q, frame_nxt;
    logic          hs, last_hs, accept, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] byte_at(input logic [FW-1:0] f, input logic [3:0] i);
        return 8'(f >> (8 * (N - 1 - int'(i))));
    endfunction

`ifdef OPFRAME_CHECKSUM_EN
    // XOR of bytes 1..13; the sync byte is excluded.
    function automatic logic [7:0] xor_bytes(input logic [PW-1:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 1; k < 14; k++) begin
            acc ^= 8'(p >> (8 * (13 - k)));
        end
        return acc;
    endfunction
`endif

    assign payload = {SYNC_BYTE, seq, 32'(tkeo_in), 32'(ed_in), aso_in, ado_in};
    assign hs      = tx_valid & tx_ready;
    assign last_hs = hs && (idx == LAST_IDX);
    assign accept  = sample_valid && ((state == IDLE) || last_hs);
    assign drop    = sample_valid && !accept;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        frame_nxt = frame_q;
        if (accept) begin
            state_nxt = SEND;
            idx_nxt   = '0;
`ifdef OPFRAME_CHECKSUM_EN
            frame_nxt = {payload, xor_bytes(payload)};
`else
            frame_nxt = payload;
`endif
        end else if (hs) begin
            if (last_hs) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + 4'd1;
            end
        end
    end

    // Stage boundary: control state and registered stream outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            if (sample_valid) seq <= seq + 8'd1;
            if (drop) drop_cnt <= sat_inc8(drop_cnt);
            tx_valid <= (state_nxt == SEND);
            tx_last  <= (state_nxt == SEND) && (idx_nxt == LAST_IDX);
            tx_data  <= (state_nxt == SEND) ? byte_at(frame_nxt, idx_nxt) : 8'h00;
        end
    end

    // Stage boundary: frame shadow register (data path, not reset)
    always_ff @(posedge clk) begin
        frame_q <= frame_nxt;
    end

    assign busy = tx_valid;

endmodule

// File: tb/tb_operator_frame_tx.sv
// Bench for operator_frame_tx: directed scenarios plus random traffic against a byte-queue frame model.
module tb_operator_frame_tx;
    localparam int OB = 29;
`ifdef OPFRAME_CHECKSUM_EN
    localparam int N = 15;
`else
    localparam int N = 14;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid = 1'b0;
    logic [OB-1:0] tkeo_in = '0;
    logic [OB-1:0] ed_in = '0;
    logic [15:0]   aso_in = '0;
    logic [15:0]   ado_in = '0;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          busy;
    logic [7:0]    drop_cnt;

    operator_frame_tx #(.OUT_BITS(OB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .tkeo_in(tkeo_in), .ed_in(ed_in), .aso_in(aso_in), .ado_in(ado_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         rem = 0;
    logic [7:0] mseq = 8'h00;
    logic [7:0] mdrop = 8'h00;
    logic [7:0] q[$];
    logic [7:0] cur[N];
    logic [7:0] last_frame[N];
    logic [8*N-1:0] gold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sv, input logic rdy, input logic [OB-1:0] tk,
                        input logic [OB-1:0] ed, input logic [15:0] as, input logic [15:0] ad);
        logic       hs, fin, acc;
        logic [31:0] tz, ez;
        logic [7:0] fb[N];
        @(negedge clk);
        chk("tx_valid", 32'(tx_valid), 32'(rem > 0));
        chk("busy", 32'(busy), 32'(rem > 0));
        chk("tx_last", 32'(tx_last), 32'(rem == 1));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        if (rem > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        sample_valid = sv;
        tx_ready     = rdy;
        tkeo_in      = tk;
        ed_in        = ed;
        aso_in       = as;
        ado_in       = ad;
        hs  = (rem > 0) && rdy;
        fin = hs && (rem == 1);
        acc = sv && ((rem == 0) || fin);
        if (hs) begin
            cur[N - rem] = tx_data;
            void'(q.pop_front());
            rem--;
            if (fin) last_frame = cur;
        end
        if (acc) begin
            tz = 32'(tk);
            ez = 32'(ed);
            fb[0]  = 8'hA5;      fb[1]  = mseq;
            fb[2]  = tz[31:24];  fb[3]  = tz[23:16]; fb[4]  = tz[15:8]; fb[5]  = tz[7:0];
            fb[6]  = ez[31:24];  fb[7]  = ez[23:16]; fb[8]  = ez[15:8]; fb[9]  = ez[7:0];
            fb[10] = as[15:8];   fb[11] = as[7:0];   fb[12] = ad[15:8]; fb[13] = ad[7:0];
`ifdef OPFRAME_CHECKSUM_EN
            fb[14] = 8'h00;
            for (int k = 1; k < 14; k++) fb[14] ^= fb[k];
`endif
            for (int k = 0; k < N; k++) q.push_back(fb[k]);
            rem = N;
        end else if (sv && mdrop != 8'hFF) begin
            mdrop++;
        end
        if (sv) mseq++;
    endtask

    task automatic rstep(input logic sv, input logic rdy);
        step(sv, rdy, OB'($urandom()), OB'($urandom()), 16'($urandom()), 16'($urandom()));
    endtask

    task automatic gstep();
        step(1'b1, 1'b1, 29'h0123_4567, 29'h0000_00FF, 16'hBEEF, 16'h0102);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rem = 0;
        mseq = 8'h00;
        mdrop = 8'h00;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Compares the last completed frame with the golden test-plan vector, seq byte replaced by s.
    task automatic chk_frame(input string tag, input logic [7:0] s);
        logic [7:0] e;
        for (int i = 0; i < N; i++) begin
            e = 8'(gold >> (8 * (N - 1 - i)));
            if (i == 1) e = s;
            if (i == 14) e ^= s;
            chk(tag, 32'(last_frame[i]), 32'(e));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        logic sv;
`ifdef OPFRAME_CHECKSUM_EN
        gold = 120'hA5_00_01234567_000000FF_BEEF_0102_AD;
`else
        gold = 112'hA5_00_01234567_000000FF_BEEF_0102;
`endif
        do_reset();

        // single frame, ready held high
        gstep();
        repeat (N + 1) rstep(1'b0, 1'b1);
        chk_frame("single_frame", 8'h00);

        // backpressure 1,0,0,1
        gstep();
        for (int i = 0; i < 4 * N; i++) rstep(1'b0, (i % 4 == 0) || (i % 4 == 3));
        chk_frame("backpressure_frame", 8'h01);

        // drop at byte 5
        do_reset();
        gstep();
        repeat (5) rstep(1'b0, 1'b1);
        rstep(1'b1, 1'b1);
        repeat (N) rstep(1'b0, 1'b1);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk_frame("drop_payload", 8'h00);
        rstep(1'b1, 1'b1);
        repeat (N + 1) rstep(1'b0, 1'b1);
        chk("drop_next_seq", 32'(last_frame[1]), 32'd2);

        // back-to-back
        do_reset();
        gstep();
        repeat (N - 1) rstep(1'b0, 1'b1);
        rstep(1'b1, 1'b1);
        rstep(1'b0, 1'b1);
        chk("b2b_sync", 32'(tx_data), 32'hA5);
        chk("b2b_valid", 32'(tx_valid), 32'd1);
        repeat (N) rstep(1'b0, 1'b1);
        chk("b2b_seq", 32'(last_frame[1]), 32'd1);
        chk("b2b_drop", 32'(drop_cnt), 32'd0);

        // reset mid-frame at byte 7
        do_reset();
        gstep();
        repeat (2) rstep(1'b0, 1'b1);
        rstep(1'b1, 1'b1);
        repeat (4) rstep(1'b0, 1'b1);
        do_reset();
        repeat (3) rstep(1'b0, 1'b1);
        gstep();
        repeat (N + 1) rstep(1'b0, 1'b1);
        chk_frame("after_reset_frame", 8'h00);

        // drop counter saturation
        do_reset();
        repeat (300) rstep(1'b1, 1'b0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        repeat (N + 2) rstep(1'b0, 1'b1);

        // seq wrap over 257 accepted frames
        do_reset();
        acc_n = 0;
        for (int c = 0; c < 300 * N && acc_n < 257; c++) begin
            sv = (rem == 0) || (rem == 1);
            rstep(sv, 1'b1);
            if (sv) acc_n++;
        end
        repeat (N + 1) rstep(1'b0, 1'b1);
        chk("wrap_seq", 32'(last_frame[1]), 32'd0);
        chk("wrap_drop", 32'(drop_cnt), 32'd0);

        // random traffic
        do_reset();
        repeat (2000) rstep($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        repeat (N + 2) rstep(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
